// File: rtl/arq_seqn_ctrl.sv
`timescale 1ns/1ps
// arq_seqn_ctrl: per-LT_ADDR ARQN/SEQN tracking and new/retransmit payload selection
module arq_seqn_ctrl (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic [2:0] ms_lt_addr,
  input  logic       regi_txdatready,
  input  logic       tx_packet_st_p,
  input  logic       hec_endp,
  input  logic       dec_hecgood,
  input  logic       dec_arqn,
  input  logic       dec_flow,
  input  logic       dec_seqn,
  input  logic       pktype_data,
  input  logic       crc_endp,
  input  logic       dec_crcgood,
  input  logic       regi_arqrst_p,
  output logic       sendnewpy,
  output logic       tx_seqn,
  output logic       tx_arqn,
  output logic       newpy_int_p,
  output logic       rx_newpy_p,
  output logic       rx_dupl_p
);
  logic [7:0] seqn_tx, acked, flowgo, txfirst, rxfirst, seqn_rx, arqn_out;
  logic       hdrok, nz, crc_ev, rx_new;
  assign nz = |ms_lt_addr;
  // LT_ADDR 0 is broadcast: no ARQ, every ready payload goes out as new
  assign sendnewpy = regi_txdatready &
                     (~nz | txfirst[ms_lt_addr] | (acked[ms_lt_addr] & flowgo[ms_lt_addr]));
  assign crc_ev = crc_endp & pktype_data & hdrok;
  assign rx_new = rxfirst[ms_lt_addr] | (dec_seqn != seqn_rx[ms_lt_addr]);
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) begin
      seqn_tx     <= 8'h00;
      acked       <= 8'h00;
      flowgo      <= 8'hff;
      txfirst     <= 8'hff;
      rxfirst     <= 8'hff;
      seqn_rx     <= 8'h00;
      arqn_out    <= 8'h00;
      hdrok       <= 1'b0;
      tx_seqn     <= 1'b0;
      tx_arqn     <= 1'b0;
      newpy_int_p <= 1'b0;
      rx_newpy_p  <= 1'b0;
      rx_dupl_p   <= 1'b0;
    end else if (regi_arqrst_p) begin
      seqn_tx     <= 8'h00;
      acked       <= 8'h00;
      flowgo      <= 8'hff;
      txfirst     <= 8'hff;
      rxfirst     <= 8'hff;
      seqn_rx     <= 8'h00;
      arqn_out    <= 8'h00;
      hdrok       <= 1'b0;
      tx_seqn     <= 1'b0;
      tx_arqn     <= 1'b0;
      newpy_int_p <= 1'b0;
      rx_newpy_p  <= 1'b0;
      rx_dupl_p   <= 1'b0;
    end else begin
      newpy_int_p <= tx_packet_st_p & sendnewpy;
      rx_newpy_p  <= crc_ev & dec_crcgood & rx_new;
      rx_dupl_p   <= crc_ev & dec_crcgood & ~rx_new;
      if (hec_endp)
        hdrok <= dec_hecgood;
      else if (tx_packet_st_p)
        hdrok <= 1'b0;
      if (hec_endp && dec_hecgood && nz) begin
        flowgo[ms_lt_addr] <= dec_flow;
        if (dec_arqn)
          acked[ms_lt_addr] <= 1'b1;
      end
      // a payload just committed is not yet acknowledged, so this clear wins over a same-cycle ack
      if (tx_packet_st_p) begin
        tx_seqn <= seqn_tx[ms_lt_addr] ^ sendnewpy;
        tx_arqn <= arqn_out[ms_lt_addr];
        if (sendnewpy) begin
          seqn_tx[ms_lt_addr] <= ~seqn_tx[ms_lt_addr];
          acked[ms_lt_addr]   <= 1'b0;
          txfirst[ms_lt_addr] <= 1'b0;
        end
      end
      if (crc_ev) begin
        arqn_out[ms_lt_addr] <= dec_crcgood & nz;
        if (dec_crcgood && rx_new) begin
          seqn_rx[ms_lt_addr] <= dec_seqn;
          rxfirst[ms_lt_addr] <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_arq_seqn_ctrl.sv
`timescale 1ns/1ps
// tb_arq_seqn_ctrl: directed checks of tx new/retransmit decisions and rx new/duplicate classification
module tb_arq_seqn_ctrl;
  logic       clk_6M = 1'b0;
  logic       rstz = 1'b0;
  logic [2:0] ms_lt_addr = 3'd0;
  logic       regi_txdatready = 1'b0;
  logic       tx_packet_st_p = 1'b0;
  logic       hec_endp = 1'b0;
  logic       dec_hecgood = 1'b0;
  logic       dec_arqn = 1'b0;
  logic       dec_flow = 1'b0;
  logic       dec_seqn = 1'b0;
  logic       pktype_data = 1'b0;
  logic       crc_endp = 1'b0;
  logic       dec_crcgood = 1'b0;
  logic       regi_arqrst_p = 1'b0;
  logic       sendnewpy, tx_seqn, tx_arqn, newpy_int_p, rx_newpy_p, rx_dupl_p;
  int         n_assert = 0;
  int         n_fail = 0;

  arq_seqn_ctrl dut (
    .clk_6M(clk_6M), .rstz(rstz), .ms_lt_addr(ms_lt_addr), .regi_txdatready(regi_txdatready),
    .tx_packet_st_p(tx_packet_st_p), .hec_endp(hec_endp), .dec_hecgood(dec_hecgood),
    .dec_arqn(dec_arqn), .dec_flow(dec_flow), .dec_seqn(dec_seqn), .pktype_data(pktype_data),
    .crc_endp(crc_endp), .dec_crcgood(dec_crcgood), .regi_arqrst_p(regi_arqrst_p),
    .sendnewpy(sendnewpy), .tx_seqn(tx_seqn), .tx_arqn(tx_arqn), .newpy_int_p(newpy_int_p),
    .rx_newpy_p(rx_newpy_p), .rx_dupl_p(rx_dupl_p)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // entered just after a falling edge; any coincident pulses set by the caller are dropped with tx_packet_st_p
  task automatic tx(input logic [2:0] a, input logic rdy, input logic e_snp,
                    input logic e_seqn, input logic e_arqn, input logic e_int, input string tag);
    ms_lt_addr = a;
    regi_txdatready = rdy;
    tx_packet_st_p = 1'b1;
    #1 chk({tag, ".sendnewpy"}, sendnewpy, e_snp);
    @(negedge clk_6M);
    tx_packet_st_p = 1'b0;
    hec_endp = 1'b0;
    regi_arqrst_p = 1'b0;
    chk({tag, ".tx_seqn"}, tx_seqn, e_seqn);
    chk({tag, ".tx_arqn"}, tx_arqn, e_arqn);
    chk({tag, ".newpy_int_p"}, newpy_int_p, e_int);
    @(negedge clk_6M);
    chk({tag, ".newpy_int_p_end"}, newpy_int_p, 1'b0);
  endtask

  task automatic hdr(input logic [2:0] a, input logic good, input logic arqn,
                     input logic flow, input logic seqn);
    ms_lt_addr = a;
    dec_hecgood = good;
    dec_arqn = arqn;
    dec_flow = flow;
    dec_seqn = seqn;
    hec_endp = 1'b1;
    @(negedge clk_6M);
    hec_endp = 1'b0;
  endtask

  task automatic crc(input logic good, input logic data, input logic e_new,
                     input logic e_dup, input string tag);
    dec_crcgood = good;
    pktype_data = data;
    crc_endp = 1'b1;
    @(negedge clk_6M);
    crc_endp = 1'b0;
    chk({tag, ".rx_newpy_p"}, rx_newpy_p, e_new);
    chk({tag, ".rx_dupl_p"}, rx_dupl_p, e_dup);
    @(negedge clk_6M);
    chk({tag, ".rx_newpy_p_end"}, rx_newpy_p, 1'b0);
    chk({tag, ".rx_dupl_p_end"}, rx_dupl_p, 1'b0);
  endtask

  initial begin
    ms_lt_addr = 3'd1;
    repeat (2) @(negedge clk_6M);
    chk("rst.tx_seqn", tx_seqn, 1'b0);
    chk("rst.tx_arqn", tx_arqn, 1'b0);
    chk("rst.newpy_int_p", newpy_int_p, 1'b0);
    chk("rst.rx_newpy_p", rx_newpy_p, 1'b0);
    chk("rst.rx_dupl_p", rx_dupl_p, 1'b0);
    chk("rst.sendnewpy_notready", sendnewpy, 1'b0);
    rstz = 1'b1;
    @(negedge clk_6M);
    // first payload to LT 1
    tx(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "first_tx");
    hdr(3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tx(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "nak_retx");
    hdr(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    tx(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ack_new");
    // flow stop holds the acked payload back until flow resumes
    hdr(3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tx(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "flow_stop");
    hdr(3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tx(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "flow_go");
    hdr(3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    tx(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "hec_bad");
    hdr(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    tx(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "not_ready");
    tx(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ready_again");
    // rx classification on LT 2
    hdr(3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    crc(1'b1, 1'b1, 1'b1, 1'b0, "rx_first");
    tx(3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "lt2_tx1");
    hdr(3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    crc(1'b1, 1'b1, 1'b0, 1'b1, "rx_dup");
    tx(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "lt2_tx2");
    hdr(3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    crc(1'b0, 1'b1, 1'b0, 1'b0, "rx_crcbad");
    tx(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lt2_tx3");
    hdr(3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    crc(1'b1, 1'b0, 1'b0, 1'b0, "rx_nodata");
    tx(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lt2_tx4");
    hdr(3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    crc(1'b1, 1'b1, 1'b0, 1'b0, "rx_hdrbad");
    hdr(3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    crc(1'b1, 1'b1, 1'b1, 1'b0, "rx_new_seqn0");
    tx(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "lt2_tx5");
    // independent LT 1 / LT 3 entries
    tx(3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "lt3_tx1");
    tx(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lt1_retx1");
    hdr(3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    crc(1'b1, 1'b1, 1'b1, 1'b0, "lt3_rx");
    tx(3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "lt3_tx2");
    tx(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lt1_retx2");
    hdr(3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    crc(1'b1, 1'b1, 1'b1, 1'b0, "lt1_rx");
    tx(3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "lt1_tx");
    // broadcast LT 0
    hdr(3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    crc(1'b1, 1'b1, 1'b1, 1'b0, "lt0_rx");
    tx(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "lt0_tx1");
    tx(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "lt0_tx2");
    // header ack in the same cycle as tx: decision uses the pre-ack state
    dec_hecgood = 1'b1; dec_arqn = 1'b1; dec_flow = 1'b1; hec_endp = 1'b1;
    tx(3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "hec_tx_same");
    tx(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "after_same");
    // MCU ARQ reset coincident with a tx that would have sent new
    hdr(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    regi_arqrst_p = 1'b1;
    tx(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "arqrst_tx");
    tx(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "post_rst_lt1");
    tx(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_lt2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/arq_seqn_ctrl.md
# arq_seqn_ctrl

ARQ/SEQN sequencer for ACL payload traffic. It tracks acknowledgement, flow and sequence-number state for each LT_ADDR 0..7. It decides whether the next transmitted packet carries a new payload or a retransmission, and drives `sendnewpy` into the payload buffer controller, which swaps the tx ACL double buffer. It also supplies the ARQN/SEQN header bits for outgoing packets and classifies received CRC payloads as new or duplicate.

## Interface
Parameters: none.

Ports:
- `clk_6M` in 1: system clock.
- `rstz` in 1: reset, asynchronous, active-low.
- `ms_lt_addr` in 3: LT_ADDR of the current slot, for both tx and rx; stable from header start to payload end.
- `regi_txdatready` in 1: level; MCU has written the next payload into the inactive tx buffer.
- `tx_packet_st_p` in 1: one-cycle pulse at tx packet start.
- `hec_endp` in 1: one-cycle pulse at end of rx header decode.
- `dec_hecgood` in 1: rx header HEC result; valid with `hec_endp`.
- `dec_arqn`, `dec_flow`, `dec_seqn` in 1 each: decoded rx header bits. Valid from `hec_endp` through `crc_endp`.
- `pktype_data` in 1: rx packet carries a CRC payload (DM/DH/AUX-less ACL).
- `crc_endp` in 1: one-cycle pulse at end of rx payload CRC check.
- `dec_crcgood` in 1: CRC result; valid with `crc_endp`.
- `regi_arqrst_p` in 1: MCU pulse; returns all per-LT_ADDR state to reset values.
- `sendnewpy` out 1: combinational; 1 means the next tx carries a new payload.
- `tx_seqn` out 1: SEQN for the current tx header.
- `tx_arqn` out 1: ARQN for the current tx header.
- `newpy_int_p` out 1: pulse to MCU; new payload committed, refill buffer.
- `rx_newpy_p` out 1: pulse; received payload is new, so keep it.
- `rx_dupl_p` out 1: pulse; received payload is a duplicate, so discard it.

## Operation
Per-entry state, 8 entries indexed by `ms_lt_addr` (a):
- `seqn_tx[a]`: reset 0.
- `acked[a]`: reset 0.
- `flowgo[a]`: reset 1.
- `txfirst[a]`: reset 1.
- `rxfirst[a]`: reset 1.
- `seqn_rx[a]`: reset 0.
- `arqn_out[a]`: reset 0.

The `sendnewpy` decision:
- For a≠0: `sendnewpy = regi_txdatready & (txfirst[a] | (acked[a] & flowgo[a]))`.
- For a=0 (broadcast, no ARQ): `sendnewpy = regi_txdatready`.

On `tx_packet_st_p`:
- `tx_seqn` <= `sendnewpy ? ~seqn_tx[a] : seqn_tx[a]`.
- `tx_arqn` <= `arqn_out[a]`.
- If `sendnewpy`: `seqn_tx[a]` toggles, `acked[a]`<=0 and `txfirst[a]`<=0.

On `hec_endp & dec_hecgood`, for a≠0:
- `flowgo[a]`<=`dec_flow`.
- If `dec_arqn`, `acked[a]`<=1. A 0 leaves `acked[a]` unchanged.

On `hec_endp & !dec_hecgood`: no state change.

On `crc_endp & pktype_data`, only if the preceding header was HEC-good (latched internally as `hdrok`, cleared at the next `hec_endp` or `tx_packet_st_p`):
- CRC good and (`rxfirst[a]` or `dec_seqn`≠`seqn_rx[a]`):
  - `arqn_out[a]`<=1, `seqn_rx[a]`<=`dec_seqn`, `rxfirst[a]`<=0.
  - Pulse `rx_newpy_p`.
- CRC good and `dec_seqn`==`seqn_rx[a]`:
  - `arqn_out[a]`<=1.
  - Pulse `rx_dupl_p`.
- CRC bad: `arqn_out[a]`<=0.

Packets without a CRC payload (NULL/POLL, `pktype_data`=0) never change `arqn_out`. For a=0, rx updates `seqn_rx`/`rxfirst` but `arqn_out[0]` stays 0.

`regi_arqrst_p` has highest priority. It restores all entries and output registers to reset values in the cycle it is seen. Any coincident event in that cycle is ignored.

## Timing
- All outputs are registered except `sendnewpy`.
- Reset values: `tx_seqn`=0, `tx_arqn`=0, `newpy_int_p`=0, `rx_newpy_p`=0, `rx_dupl_p`=0.
- `sendnewpy` is valid in the `tx_packet_st_p` cycle, combinational from state, `ms_lt_addr` and `regi_txdatready`. It reflects state before any same-cycle update.
- `tx_seqn`/`tx_arqn` update in the cycle after `tx_packet_st_p` and hold until the next `tx_packet_st_p`.
- `newpy_int_p` is a single pulse, one cycle after `tx_packet_st_p & sendnewpy`.
- `rx_newpy_p`/`rx_dupl_p` are single pulses, one cycle after `crc_endp`; the two are mutually exclusive.
- `hec_endp` and `tx_packet_st_p` in the same cycle: both updates are applied, and `sendnewpy` uses pre-update `acked`/`flowgo`.
- `hec_endp` and `crc_endp` in the same cycle: the CRC event uses the `hdrok` value held before that `hec_endp`.
- Reset mid-packet: state returns to reset values immediately, and pulses are not generated.

## Test plan
- Reset, then `ms_lt_addr`=1, `regi_txdatready`=1, `tx_packet_st_p` → `sendnewpy`=1, `tx_seqn`=1 next cycle, `newpy_int_p` pulses one cycle later, `seqn_tx[1]`=1.
- Then rx header a=1 with hecgood=1, arqn=0, followed by tx → `sendnewpy`=0, `tx_seqn` stays 1, no `newpy_int_p`. Rx arqn=1, flow=1, then tx → `sendnewpy`=1, `tx_seqn`=0.
- Ack with flow=0 → `sendnewpy`=0 until a header with flow=1 arrives. `dec_hecgood`=0 with arqn=1 → `acked` unchanged.
- Rx a=2, CRC payload seqn=1, crcgood → `rx_newpy_p`, next tx `tx_arqn`=1. Repeat seqn=1 → `rx_dupl_p`, `tx_arqn`=1. Seqn=0 with crcgood=0 → `tx_arqn`=0 and no pulse.
- Interleave a=1 and a=3 traffic → each entry's SEQN/ARQN toggles independently. a=0 always sends new with `regi_txdatready`=1, and `tx_arqn`=0.
- `regi_arqrst_p` coincident with `tx_packet_st_p` → no `newpy_int_p`, all entries at reset, and the next tx to a=1 starts again with `tx_seqn`=1.
